md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer with HI/LO registers for the 5-stage pipeline.
//  Sits in the E stage beside the ALU and accepts one MD operation per start pulse.
//  It counts out the fixed operation latency, then commits the result to HI/LO.
//  It also produces the stall request that freezes the F/D registers and bubbles the D/E register.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy after a MULT/MULTU start (>=1)
//  DIV_CYCLES   10  cycles busy after a DIV/DIVU start (>=1)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  start     in   1   E-stage instr is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//  md_op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
//  md_wr     in   1   E-stage instr is MTHI/MTLO (selected by md_op)
//  rs_val    in   32  operand A (dividend / multiplicand / MT source)
//  rt_val    in   32  operand B (divisor / multiplier)
//  md_use_D  in   1   D-stage instr is MULT/DIV/MFHI/MFLO/MTHI/MTLO
//  busy      out  1   operation in flight
//  stall_md  out  1   stall request = md_use_D & (start | busy); combinational
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (any time, including mid-operation):
//    - state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result discarded.
//    - stall_md follows its equation.
//  - FSM IDLE/MUL/DIV:
//    - IDLE & start & op MULT*: go to MUL, cnt=MULT_CYCLES-1.
//    - IDLE & start & op DIV*: go to DIV, cnt=DIV_CYCLES-1.
//    - MUL/DIV: cnt decrements each cycle.
//    - When cnt==0: commit hi/lo and return to IDLE in the same edge.
//  - Operand capture:
//    - Operands are latched, and the result computed into a pending register, on the start edge.
//    - Later changes of rs_val/rt_val have no effect on the result.
//  - Latency:
//    - busy=1 for exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
//    - New hi/lo are visible in the first cycle busy=0.
//  - Arithmetic:
//    - MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned product.
//    - DIV: lo = trunc-toward-zero quotient, hi = remainder with the dividend's sign.
//    - DIVU: unsigned quotient and remainder.
//    - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//    - Divisor 0 (DIV/DIVU): full DIV_CYCLES busy, hi/lo left unchanged.
//  - MTHI/MTLO:
//    - Taken only when md_wr=1 and state=IDLE.
//    - Write hi (or lo) = rs_val at the next edge; busy stays 0.
//  - Illegal overlap: start or md_wr while busy is ignored. The pipeline prevents this via stall_md.
//  - Simultaneous start & md_wr in IDLE: start wins, and the write is dropped.
//  - md_op values 6-7 with start=1: no-op, FSM stays IDLE.
// TESTING
//  - MULT rs=3 rt=0xFFFFFFFE -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - MULTU rs=0xFFFFFFFF rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  - DIV rs=0xFFFFFFF9(-7) rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    DIVU 7/2 -> lo=3, hi=1.
//  - DIV by 0 with hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo stay 0x11/0x22.
//  - start MULT with md_use_D=1 -> stall_md=1 in the start cycle and all 5 busy cycles.
//    stall_md=0 once busy falls. MTLO rs=0xABCD while idle -> lo=0xABCD next cycle.
//  - Assert reset 2 cycles into DIV -> busy=0, hi=lo=0 immediately (async).
//    After release, no late commit.

Source files
------------

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
//   Bundles the E-stage multiply/divide request signals, the D-stage use flag
//   and the HI/LO/busy/stall results of md_unit_ctrl.
//   master : pipeline side (drives requests, observes results)
//   slave  : md_unit_ctrl side
//   Signals:
//     start    E-stage instr is MULT/MULTU/DIV/DIVU (one-cycle pulse)
//     md_op    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//     md_wr    E-stage instr is MTHI/MTLO
//     rs_val   operand A / MT source
//     rt_val   operand B
//     md_use_D D-stage instr touches the MD unit
//     busy     operation in flight
//     stall_md stall request to the F/D and D/E registers
//     hi, lo   architectural HI/LO registers
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic        md_wr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, md_wr, rs_val, rt_val, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, md_wr, rs_val, rt_val, md_use_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Multi-cycle multiply/divide sequencer with HI/LO registers, placed in the
//   E stage beside the ALU. The result is computed into a pending register on
//   the start edge, the fixed latency is counted out, and the result is then
//   committed to HI/LO. Also produces the stall request for the F/D and D/E
//   registers.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no operation in flight; accepts start or an MTHI/MTLO write
//   MUL   | multiply in flight, counting down MULT_CYCLES
//   DIV   | divide in flight, counting down DIV_CYCLES
//
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  asynchronous, active-high; clears all state
//     bus      md_unit_ctrl_if.slave (requests in, busy/stall/hi/lo out)
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  md_unit_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_pend_hi;
  logic [31:0]   r_pend_lo;
  logic          r_pend_valid;

  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic          w_div_zero;
  logic          w_div_ovf;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;
  logic          w_res_valid;

  assign w_prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                    $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign w_prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  assign w_div_zero = (bus.rt_val == 32'd0);
  // The one signed quotient that does not fit in 32 bits; pinned explicitly
  // rather than trusting the wrap behaviour of the divider.
  assign w_div_ovf  = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);

  always_comb begin
    w_res_hi    = 32'd0;
    w_res_lo    = 32'd0;
    w_res_valid = 1'b0;
    case (bus.md_op)
      3'd0: begin
        w_res_hi    = w_prod_s[63:32];
        w_res_lo    = w_prod_s[31:0];
        w_res_valid = 1'b1;
      end
      3'd1: begin
        w_res_hi    = w_prod_u[63:32];
        w_res_lo    = w_prod_u[31:0];
        w_res_valid = 1'b1;
      end
      3'd2: begin
        if (w_div_zero) begin
          w_res_valid = 1'b0;
        end else if (w_div_ovf) begin
          w_res_hi    = 32'd0;
          w_res_lo    = 32'h8000_0000;
          w_res_valid = 1'b1;
        end else begin
          w_res_hi    = $signed(bus.rs_val) % $signed(bus.rt_val);
          w_res_lo    = $signed(bus.rs_val) / $signed(bus.rt_val);
          w_res_valid = 1'b1;
        end
      end
      3'd3: begin
        if (!w_div_zero) begin
          w_res_hi    = bus.rs_val % bus.rt_val;
          w_res_lo    = bus.rs_val / bus.rt_val;
          w_res_valid = 1'b1;
        end
      end
      default: begin
        w_res_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
      r_pend_hi    <= 32'd0;
      r_pend_lo    <= 32'd0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // start takes priority over an MTHI/MTLO arriving in the same cycle.
          if (bus.start) begin
            if (bus.md_op == 3'd0 || bus.md_op == 3'd1) begin
              r_state      <= MUL;
              r_cnt        <= MUL_LOAD;
              r_busy       <= 1'b1;
              r_pend_hi    <= w_res_hi;
              r_pend_lo    <= w_res_lo;
              r_pend_valid <= w_res_valid;
            end else if (bus.md_op == 3'd2 || bus.md_op == 3'd3) begin
              r_state      <= DIV;
              r_cnt        <= DIV_LOAD;
              r_busy       <= 1'b1;
              r_pend_hi    <= w_res_hi;
              r_pend_lo    <= w_res_lo;
              r_pend_valid <= w_res_valid;
            end
          end else if (bus.md_wr) begin
            if (bus.md_op == 3'd4) begin
              r_hi <= bus.rs_val;
            end else if (bus.md_op == 3'd5) begin
              r_lo <= bus.rs_val;
            end
          end
        end
        MUL, DIV: begin
          // Requests arriving here are ignored; the pipeline stalls them.
          if (r_cnt == '0) begin
            // Divide-by-zero leaves pend_valid low so HI/LO keep their value.
            if (r_pend_valid) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_valid <= 1'b0;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.stall_md = bus.md_use_D & (bus.start | r_busy);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start pulse and returns how many negedges busy stayed high.
  // Operands are scrambled right after the start edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.rs_val = 32'hDEAD_BEEF;
    bus.rt_val = 32'h1234_5678;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic write_mt(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    bus.md_wr  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = v;
    @(negedge clk);
    bus.md_wr  = 1'b0;
    bus.rs_val = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if (bus.hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", bus.lo); else passed++;
    checks++; if (bus.stall_md !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stall_md); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    run_op(3'd0, 32'd3, 32'hFFFF_FFFE, n);
    checks++; if (n !== 5) $display("FAIL mult_latency got=%0d exp=5", n); else passed++;
    checks++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); else passed++;
  endtask

  task automatic test_multu();
    int n;
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    checks++; if (n !== 5) $display("FAIL multu_latency got=%0d exp=5", n); else passed++;
    checks++; if (bus.hi !== 32'h0000_0001) $display("FAIL multu_hi got=%h exp=00000001", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); else passed++;
  endtask

  task automatic test_div();
    int n;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n !== 10) $display("FAIL div_latency got=%0d exp=10", n); else passed++;
    checks++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); else passed++;
    run_op(3'd3, 32'd7, 32'd2, n);
    checks++; if (n !== 10) $display("FAIL divu_latency got=%0d exp=10", n); else passed++;
    checks++; if (bus.lo !== 32'd3) $display("FAIL divu_lo got=%h exp=3", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd1) $display("FAIL divu_hi got=%h exp=1", bus.hi); else passed++;
  endtask

  task automatic test_div_overflow();
    int n;
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (bus.lo !== 32'h8000_0000) $display("FAIL divovf_lo got=%h exp=80000000", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd0) $display("FAIL divovf_hi got=%h exp=0", bus.hi); else passed++;
  endtask

  task automatic test_mt();
    write_mt(3'd4, 32'h11);
    checks++; if (bus.hi !== 32'h11) $display("FAIL mthi got=%h exp=11", bus.hi); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL mthi_busy got=%b exp=0", bus.busy); else passed++;
    write_mt(3'd5, 32'h22);
    checks++; if (bus.lo !== 32'h22) $display("FAIL mtlo got=%h exp=22", bus.lo); else passed++;
  endtask

  task automatic test_div_zero();
    int n;
    run_op(3'd2, 32'd5, 32'd0, n);
    checks++; if (n !== 10) $display("FAIL divzero_latency got=%0d exp=10", n); else passed++;
    checks++; if (bus.hi !== 32'h11) $display("FAIL divzero_hi got=%h exp=11", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'h22) $display("FAIL divzero_lo got=%h exp=22", bus.lo); else passed++;
  endtask

  task automatic test_stall();
    bus.md_use_D = 1'b1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'd4;
    bus.rt_val = 32'd5;
    #1;
    checks++; if (bus.stall_md !== 1'b1) $display("FAIL stall_start got=%b exp=1", bus.stall_md); else passed++;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.stall_md !== 1'b1)
        $display("FAIL stall_busy cycle=%0d got busy=%b stall=%b exp 1/1", i, bus.busy, bus.stall_md);
      else passed++;
      @(negedge clk);
    end
    checks++; if (bus.stall_md !== 1'b0) $display("FAIL stall_release got=%b exp=0", bus.stall_md); else passed++;
    checks++; if (bus.lo !== 32'd20) $display("FAIL stall_mult_lo got=%h exp=14", bus.lo); else passed++;
    bus.md_use_D = 1'b0;
    write_mt(3'd5, 32'hABCD);
    checks++; if (bus.lo !== 32'hABCD) $display("FAIL mtlo_abcd got=%h exp=abcd", bus.lo); else passed++;
  endtask

  task automatic test_overlap();
    int n;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd3;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.md_wr  = 1'b1;
    bus.md_op  = 3'd4;
    bus.rs_val = 32'h55;
    @(negedge clk);
    bus.md_wr  = 1'b0;
    bus.start  = 1'b1;
    bus.md_op  = 3'd0;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    n = 3;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 10) $display("FAIL overlap_latency got=%0d exp=10", n); else passed++;
    checks++; if (bus.lo !== 32'd14) $display("FAIL overlap_lo got=%h exp=e", bus.lo); else passed++;
    checks++; if (bus.hi !== 32'd2) $display("FAIL overlap_hi got=%h exp=2", bus.hi); else passed++;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL overlap_idle got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_noop();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd6;
    bus.rs_val = 32'd8;
    bus.rt_val = 32'd8;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL noop_busy got=%b exp=0", bus.busy); else passed++;
    repeat (6) @(negedge clk);
    checks++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14)
      $display("FAIL noop_hilo got=%h/%h exp=2/e", bus.hi, bus.lo); else passed++;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd2;
    bus.rs_val = 32'hFFFF_FFF9;
    bus.rt_val = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL midreset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0)
      $display("FAIL midreset_late got=%h/%h busy=%b exp=0/0/0", bus.hi, bus.lo, bus.busy); else passed++;
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.md_wr    = 1'b0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.md_use_D = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_mt();
    test_div_zero();
    test_stall();
    test_overlap();
    test_noop();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
